des_sbox_engine: RTL and testbench
==================================

Name: des_sbox_engine

Overview:
- Iterative, parametrised DES S-box substitution unit for the round datapath.
- Takes the 48-bit post-XOR expansion word and returns the 32-bit S-box output.
- Evaluates LANES S-boxes per clock instead of all eight combinationally, so area can be traded against latency.
- Carries a round tag through with valid/ready handshakes on both sides, so it can sit between the key-mix stage and the P-permutation stage under backpressure.

Parameters:
- LANES, 2, S-boxes evaluated per cycle. Legal values: 1, 2, 4, 8. Any other value is an elaboration error.
- ROUND_W, 4, width of the round tag.

Ports:
- clk  in  1  system clock. All state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data/in_round are valid.
- in_ready  out  1  engine can accept an input this cycle.
- in_data  in  48  expanded, key-mixed half-block. Bits 47:42 feed S1, …, bits 5:0 feed S8.
- in_round  in  ROUND_W  round tag.
- out_valid  out  1  out_data/out_round hold a completed result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  S1 result in 31:28, …, S8 result in 3:0.
- out_round  out  ROUND_W  in_round + 1, modulo 2^ROUND_W.
- busy  out  1  high in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: state=IDLE, out_valid=0, out_data=0, out_round=0, busy=0, box index=0, accumulator=0. in_ready is 1 as soon as rst_n is high.
- S-box lookup: row = {b5,b0}, column = b4:b1 of each 6-bit group. Tables are the standard FIPS 46-3 S1..S8.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data and in_round, set box index=0, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, evaluate boxes idx..idx+LANES-1 and write their nibbles into the internal accumulator. Then idx += LANES.
  - After the cycle that evaluates box 7, go to DONE. On that same edge, load out_data from the full accumulator, load out_round = captured tag + 1 (wraps, e.g. 15 -> 0 for ROUND_W=4), and set out_valid=1.
  - out_data never shows partial results.
- Latency: input accepted at edge N; out_valid rises at edge N + 8/LANES. That is 1 cycle for LANES=8 and 8 cycles for LANES=1.
- DONE:
  - out_valid=1; out_data and out_round are held stable until out_valid&&out_ready.
  - in_ready = out_ready, so back-to-back operation is allowed.
  - On out_ready with no in_valid: clear out_valid, go to IDLE.
  - On out_ready with in_valid: clear out_valid, capture the new input, go to RUN. No bubble on the input side.
- Data and round registers hold their last values after out_valid drops.
- in_valid while in RUN: ignored, not captured. The source must hold its request, per standard valid/ready rules.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The in-flight result is discarded; no out_valid is produced for it.
- Inputs are sampled only on acceptance. Changes to in_data during RUN have no effect.

Decomposition:
- Shared package des_pkg holds:
  - the S-box tables, as a constant array [8][64] of 4-bit values;
  - the function sbox_lookup(box_idx, six_bits);
  - the state enum {IDLE, RUN, DONE};
  - the localparam NUM_SBOX=8.
- One sub-module, des_sbox_lane: combinational, box index + 6 bits in, 4 bits out.
- des_sbox_engine instantiates LANES copies of des_sbox_lane, with a mux selecting the 6-bit groups by box index.

Test Plan:
1. LANES=2, in_data=48'h0, in_round=3 -> out_valid 4 cycles after acceptance, out_data=32'hEFA72C4D, out_round=4.
2. LANES=1 and LANES=8, in_data=48'hFFFFFFFFFFFF -> out_data=32'hD9CE3DCB, with latency 8 and 1 cycles respectively.
3. Wrap: in_round=15, ROUND_W=4 -> out_round=0.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data and out_round stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new input accepted on the same edge, next result valid 8/LANES cycles later.
5. Reset mid-operation: rst_n pulsed low 2 cycles after acceptance -> all outputs 0 immediately, no out_valid afterwards, in_ready=1 after release.
6. Random 48-bit vectors, 1000 iterations, all legal LANES values -> out_data matches the reference software model, and in/out transaction counts match.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES S-box definitions: FIPS 46-3 tables, lookup helper and engine state encoding.
package des_pkg;

    localparam int NUM_SBOX = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Each box is stored row-major: entry index = {row[1:0], column[3:0]}.
    localparam logic [3:0] SBOX_TABLE [NUM_SBOX][64] = '{
        '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8, 4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7,
          4'h0, 4'hF, 4'h7, 4'h4, 4'hE, 4'h2, 4'hD, 4'h1, 4'hA, 4'h6, 4'hC, 4'hB, 4'h9, 4'h5, 4'h3, 4'h8,
          4'h4, 4'h1, 4'hE, 4'h8, 4'hD, 4'h6, 4'h2, 4'hB, 4'hF, 4'hC, 4'h9, 4'h7, 4'h3, 4'hA, 4'h5, 4'h0,
          4'hF, 4'hC, 4'h8, 4'h2, 4'h4, 4'h9, 4'h1, 4'h7, 4'h5, 4'hB, 4'h3, 4'hE, 4'hA, 4'h0, 4'h6, 4'hD},
        '{4'hF, 4'h1, 4'h8, 4'hE, 4'h6, 4'hB, 4'h3, 4'h4, 4'h9, 4'h7, 4'h2, 4'hD, 4'hC, 4'h0, 4'h5, 4'hA,
          4'h3, 4'hD, 4'h4, 4'h7, 4'hF, 4'h2, 4'h8, 4'hE, 4'hC, 4'h0, 4'h1, 4'hA, 4'h6, 4'h9, 4'hB, 4'h5,
          4'h0, 4'hE, 4'h7, 4'hB, 4'hA, 4'h4, 4'hD, 4'h1, 4'h5, 4'h8, 4'hC, 4'h6, 4'h9, 4'h3, 4'h2, 4'hF,
          4'hD, 4'h8, 4'hA, 4'h1, 4'h3, 4'hF, 4'h4, 4'h2, 4'hB, 4'h6, 4'h7, 4'hC, 4'h0, 4'h5, 4'hE, 4'h9},
        '{4'hA, 4'h0, 4'h9, 4'hE, 4'h6, 4'h3, 4'hF, 4'h5, 4'h1, 4'hD, 4'hC, 4'h7, 4'hB, 4'h4, 4'h2, 4'h8,
          4'hD, 4'h7, 4'h0, 4'h9, 4'h3, 4'h4, 4'h6, 4'hA, 4'h2, 4'h8, 4'h5, 4'hE, 4'hC, 4'hB, 4'hF, 4'h1,
          4'hD, 4'h6, 4'h4, 4'h9, 4'h8, 4'hF, 4'h3, 4'h0, 4'hB, 4'h1, 4'h2, 4'hC, 4'h5, 4'hA, 4'hE, 4'h7,
          4'h1, 4'hA, 4'hD, 4'h0, 4'h6, 4'h9, 4'h8, 4'h7, 4'h4, 4'hF, 4'hE, 4'h3, 4'hB, 4'h5, 4'h2, 4'hC},
        '{4'h7, 4'hD, 4'hE, 4'h3, 4'h0, 4'h6, 4'h9, 4'hA, 4'h1, 4'h2, 4'h8, 4'h5, 4'hB, 4'hC, 4'h4, 4'hF,
          4'hD, 4'h8, 4'hB, 4'h5, 4'h6, 4'hF, 4'h0, 4'h3, 4'h4, 4'h7, 4'h2, 4'hC, 4'h1, 4'hA, 4'hE, 4'h9,
          4'hA, 4'h6, 4'h9, 4'h0, 4'hC, 4'hB, 4'h7, 4'hD, 4'hF, 4'h1, 4'h3, 4'hE, 4'h5, 4'h2, 4'h8, 4'h4,
          4'h3, 4'hF, 4'h0, 4'h6, 4'hA, 4'h1, 4'hD, 4'h8, 4'h9, 4'h4, 4'h5, 4'hB, 4'hC, 4'h7, 4'h2, 4'hE},
        '{4'h2, 4'hC, 4'h4, 4'h1, 4'h7, 4'hA, 4'hB, 4'h6, 4'h8, 4'h5, 4'h3, 4'hF, 4'hD, 4'h0, 4'hE, 4'h9,
          4'hE, 4'hB, 4'h2, 4'hC, 4'h4, 4'h7, 4'hD, 4'h1, 4'h5, 4'h0, 4'hF, 4'hA, 4'h3, 4'h9, 4'h8, 4'h6,
          4'h4, 4'h2, 4'h1, 4'hB, 4'hA, 4'hD, 4'h7, 4'h8, 4'hF, 4'h9, 4'hC, 4'h5, 4'h6, 4'h3, 4'h0, 4'hE,
          4'hB, 4'h8, 4'hC, 4'h7, 4'h1, 4'hE, 4'h2, 4'hD, 4'h6, 4'hF, 4'h0, 4'h9, 4'hA, 4'h4, 4'h5, 4'h3},
        '{4'hC, 4'h1, 4'hA, 4'hF, 4'h9, 4'h2, 4'h6, 4'h8, 4'h0, 4'hD, 4'h3, 4'h4, 4'hE, 4'h7, 4'h5, 4'hB,
          4'hA, 4'hF, 4'h4, 4'h2, 4'h7, 4'hC, 4'h9, 4'h5, 4'h6, 4'h1, 4'hD, 4'hE, 4'h0, 4'hB, 4'h3, 4'h8,
          4'h9, 4'hE, 4'hF, 4'h5, 4'h2, 4'h8, 4'hC, 4'h3, 4'h7, 4'h0, 4'h4, 4'hA, 4'h1, 4'hD, 4'hB, 4'h6,
          4'h4, 4'h3, 4'h2, 4'hC, 4'h9, 4'h5, 4'hF, 4'hA, 4'hB, 4'hE, 4'h1, 4'h7, 4'h6, 4'h0, 4'h8, 4'hD},
        '{4'h4, 4'hB, 4'h2, 4'hE, 4'hF, 4'h0, 4'h8, 4'hD, 4'h3, 4'hC, 4'h9, 4'h7, 4'h5, 4'hA, 4'h6, 4'h1,
          4'hD, 4'h0, 4'hB, 4'h7, 4'h4, 4'h9, 4'h1, 4'hA, 4'hE, 4'h3, 4'h5, 4'hC, 4'h2, 4'hF, 4'h8, 4'h6,
          4'h1, 4'h4, 4'hB, 4'hD, 4'hC, 4'h3, 4'h7, 4'hE, 4'hA, 4'hF, 4'h6, 4'h8, 4'h0, 4'h5, 4'h9, 4'h2,
          4'h6, 4'hB, 4'hD, 4'h8, 4'h1, 4'h4, 4'hA, 4'h7, 4'h9, 4'h5, 4'h0, 4'hF, 4'hE, 4'h2, 4'h3, 4'hC},
        '{4'hD, 4'h2, 4'h8, 4'h4, 4'h6, 4'hF, 4'hB, 4'h1, 4'hA, 4'h9, 4'h3, 4'hE, 4'h5, 4'h0, 4'hC, 4'h7,
          4'h1, 4'hF, 4'hD, 4'h8, 4'hA, 4'h3, 4'h7, 4'h4, 4'hC, 4'h5, 4'h6, 4'hB, 4'h0, 4'hE, 4'h9, 4'h2,
          4'h7, 4'hB, 4'h4, 4'h1, 4'h9, 4'hC, 4'hE, 4'h2, 4'h0, 4'h6, 4'hA, 4'hD, 4'hF, 4'h3, 4'h5, 4'h8,
          4'h2, 4'h1, 4'hE, 4'h7, 4'h4, 4'hA, 4'h8, 4'hD, 4'hF, 4'hC, 4'h9, 4'h0, 4'h3, 4'h5, 4'h6, 4'hB}
    };

    // Row comes from the outer bits {b5,b0}, column from the inner bits b4:b1.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box_idx, input logic [5:0] six_bits);
        return SBOX_TABLE[box_idx][{six_bits[5], six_bits[0], six_bits[4:1]}];
    endfunction

endpackage

// File: rtl/des_sbox_lane.sv
// One S-box evaluator: selected box index plus its 6-bit group in, 4-bit substitution out.
module des_sbox_lane
    import des_pkg::*;
(
    input  logic [2:0] box_idx,
    input  logic [5:0] six_bits,
    output logic [3:0] nibble
);

    assign nibble = sbox_lookup(box_idx, six_bits);

endmodule

// File: rtl/des_sbox_engine.sv
// Iterative DES S-box stage: LANES boxes per cycle, round tag carried through,
// valid/ready on both sides with back-to-back acceptance from DONE.
module des_sbox_engine
    import des_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [47:0]        in_data,
    input  logic [ROUND_W-1:0] in_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [ROUND_W-1:0] out_round,
    output logic               busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    localparam logic [2:0] LAST_IDX = 3'(NUM_SBOX - LANES);
    localparam logic [2:0] STEP     = 3'(LANES);

    state_t               state_q, state_d;
    logic [2:0]           idx_q;
    logic [47:0]          data_q;
    logic [ROUND_W-1:0]   round_q;
    logic [31:0]          acc_q, acc_d;
    logic                 accept, last_step;

    logic [LANES-1:0][2:0] box;
    logic [LANES-1:0][5:0] grp;
    logic [LANES-1:0][3:0] nib;

    // Box b reads bits 47-6b down and writes nibble 31-4b down (S1 is most significant).
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign box[g] = idx_q + 3'(g);
        assign grp[g] = data_q[6*(NUM_SBOX-1-int'(box[g])) +: 6];

        des_sbox_lane u_lane (
            .box_idx  (box[g]),
            .six_bits (grp[g]),
            .nibble   (nib[g])
        );
    end

    always_comb begin
        acc_d = acc_q;
        for (int g = 0; g < LANES; g++) begin
            acc_d[4*(NUM_SBOX-1-int'(box[g])) +: 4] = nib[g];
        end
    end

    assign last_step = (idx_q == LAST_IDX);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_d = in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            data_q    <= '0;
            round_q   <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_round <= '0;
        end else begin
            if (accept) begin
                data_q  <= in_data;
                round_q <= in_round;
                idx_q   <= '0;
            end
            if (state_q == RUN) begin
                acc_q <= acc_d;
                idx_q <= idx_q + STEP;
                // Publish only the complete word, including this cycle's nibbles.
                if (last_step) begin
                    out_data  <= acc_d;
                    out_round <= round_q + 1'b1;
                    out_valid <= 1'b1;
                end
            end
            if (state_q == DONE && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_des_sbox_engine.sv
// Directed and model-checked bench for des_sbox_engine, one instance per legal LANES value.
module tb_des_sbox_engine;

    localparam int NK = 4;  // instance k has LANES = 1 << k

    // Independent reference table: one 64-bit word per row, column 0 in the top nibble.
    localparam logic [63:0] TB_SB [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid [NK];
    logic        in_ready [NK];
    logic [47:0] in_data  [NK];
    logic [3:0]  in_round [NK];
    logic        out_valid[NK];
    logic        out_ready[NK];
    logic [31:0] out_data [NK];
    logic [3:0]  out_round[NK];
    logic        busy     [NK];

    int tests = 0;
    int fails = 0;
    int in_cnt [NK] = '{default: 0};
    int out_cnt[NK] = '{default: 0};

    always #5 clk = ~clk;

    for (genvar k = 0; k < NK; k++) begin : g_dut
        des_sbox_engine #(.LANES(1 << k), .ROUND_W(4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .in_data   (in_data[k]),
            .in_round  (in_round[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k]),
            .out_round (out_round[k]),
            .busy      (busy[k])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (in_valid[k] && in_ready[k])   in_cnt[k]  <= in_cnt[k] + 1;
            if (out_valid[k] && out_ready[k]) out_cnt[k] <= out_cnt[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_sbox(input logic [47:0] d);
        logic [31:0] res;
        logic [5:0]  g;
        logic [63:0] w;
        res = '0;
        for (int b = 0; b < 8; b++) begin
            g = d[47-6*b -: 6];
            w = TB_SB[b][{g[5], g[0]}];
            res[31-4*b -: 4] = w[63-4*int'(g[4:1]) -: 4];
        end
        return res;
    endfunction

    // Offer one input; rel also raises out_ready for a same-edge DONE handoff.
    task automatic send(input int k, input logic [47:0] d, input logic [3:0] r, input bit rel);
        in_valid[k]  = 1'b1;
        in_data[k]   = d;
        in_round[k]  = r;
        out_ready[k] = rel;
        #1;
        chk($sformatf("in_ready_k%0d", k), 64'(in_ready[k]), 64'd1);
        @(posedge clk); #1;
        in_valid[k]  = 1'b0;
        in_data[k]   = ~d;
        in_round[k]  = ~r;
        out_ready[k] = 1'b0;
    endtask

    task automatic wait_result(input int k, input logic [31:0] ed, input logic [3:0] er,
                               input string tag, input int lat0);
        int lat = lat0;
        chk({tag, "_busy"}, 64'(busy[k]), 64'd1);
        chk({tag, "_nopartial"}, 64'(out_valid[k]), 64'd0);
        while (!out_valid[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(8 >> k));
        chk({tag, "_data"}, 64'(out_data[k]), 64'(ed));
        chk({tag, "_round"}, 64'(out_round[k]), 64'(er));
    endtask

    task automatic release_out(input int k, input string tag);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk({tag, "_valid_cleared"}, 64'(out_valid[k]), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] d;
        logic [3:0]  r;
        bit          seen;
        int          in0, out0;

        for (int k = 0; k < NK; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            in_data[k]   = '0;
            in_round[k]  = '0;
        end

        #1;
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("rst_valid_k%0d", k), 64'(out_valid[k]), 64'd0);
            chk($sformatf("rst_data_k%0d", k),  64'(out_data[k]),  64'd0);
            chk($sformatf("rst_round_k%0d", k), 64'(out_round[k]), 64'd0);
            chk($sformatf("rst_busy_k%0d", k),  64'(busy[k]),      64'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // LANES=2 on all-zero input; an in_valid during RUN must be ignored.
        send(1, 48'h0, 4'd3, 0);
        in_valid[1] = 1'b1;
        in_data[1]  = 48'hFFFF_FFFF_FFFF;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        wait_result(1, 32'hEFA72C4D, 4'd4, "zero_l2", 1);
        release_out(1, "zero_l2");

        // All-ones at LANES=1 and LANES=8; alternating bits with tag wrap at LANES=4.
        send(0, 48'hFFFF_FFFF_FFFF, 4'd9, 0);
        wait_result(0, 32'hD9CE3DCB, 4'd10, "ones_l1", 0);
        release_out(0, "ones_l1");
        send(3, 48'hFFFF_FFFF_FFFF, 4'd0, 0);
        wait_result(3, 32'hD9CE3DCB, 4'd1, "ones_l8", 0);
        release_out(3, "ones_l8");
        send(2, 48'h5555_5555_5555, 4'd15, 0);
        wait_result(2, 32'hC152FD56, 4'd0, "alt_wrap_l4", 0);
        release_out(2, "alt_wrap_l4");

        // Backpressure hold, then same-edge handoff to a new input.
        send(1, 48'h5555_5555_5555, 4'd7, 0);
        wait_result(1, 32'hC152FD56, 4'd8, "bp", 0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_in_ready_low", 64'(in_ready[1]), 64'd0);
        end
        chk("bp_hold_valid", 64'(out_valid[1]), 64'd1);
        chk("bp_hold_data",  64'(out_data[1]),  64'hC152FD56);
        chk("bp_hold_round", 64'(out_round[1]), 64'd8);
        send(1, 48'h0, 4'd15, 1);
        wait_result(1, 32'hEFA72C4D, 4'd0, "b2b", 0);
        release_out(1, "b2b");

        // Reset two cycles into a LANES=1 operation discards it.
        send(0, 48'h1234_5678_9ABC, 4'd2, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid[0]), 64'd0);
        chk("midrst_data",  64'(out_data[0]),  64'd0);
        chk("midrst_round", 64'(out_round[0]), 64'd0);
        chk("midrst_busy",  64'(busy[0]),      64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid[0]) seen = 1'b1;
        end
        chk("midrst_no_valid", 64'(seen), 64'd0);
        chk("midrst_in_ready", 64'(in_ready[0]), 64'd1);

        // Random vectors against the reference model, with random backpressure and handoff.
        for (int k = 0; k < NK; k++) begin
            in0  = in_cnt[k];
            out0 = out_cnt[k];
            d = {16'($urandom), $urandom};
            r = 4'($urandom);
            send(k, d, r, 0);
            for (int i = 0; i < 250; i++) begin
                wait_result(k, ref_sbox(d), 4'(r + 4'd1), $sformatf("rnd_k%0d", k), 0);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if (i < 249) begin
                    d = {16'($urandom), $urandom};
                    r = 4'($urandom);
                    send(k, d, r, 1);
                end else begin
                    release_out(k, $sformatf("rnd_k%0d_last", k));
                end
            end
            @(posedge clk); #1;
            chk($sformatf("rnd_k%0d_txn_balance", k), 64'(in_cnt[k] - in0), 64'(out_cnt[k] - out0));
            chk($sformatf("rnd_k%0d_txn_count", k), 64'(in_cnt[k] - in0), 64'd250);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
